// File: rtl/ysyx_22040386_clint.sv
// ----------------------------------------------------------------------------
// ysyx_22040386_clint -- core-local interruptor
//
// Memory-mapped responder on the MEM-stage data port. Holds the software
// interrupt bit (msip), the timer compare register (mtimecmp) and the
// free-running timer (mtime), and drives the machine timer / software
// interrupt lines into the CSR block.
//
// Ports:
//   i_CLINT_clk / i_CLINT_rst          clock, asynchronous active-high reset
//   i_CLINT_req_valid / o_CLINT_req_ready
//                                      request handshake (one outstanding)
//   i_CLINT_req_addr                   64-bit byte address
//   i_CLINT_req_wen                    1 = write, 0 = read
//   i_CLINT_req_wdata / i_CLINT_req_wmask
//                                      write data and byte enables
//   o_CLINT_rsp_valid / i_CLINT_rsp_ready
//                                      response handshake
//   o_CLINT_rsp_rdata                  read data (0 for writes and errors)
//   o_CLINT_rsp_err                    unmapped offset or outside window
//   o_CLINT_mtip / o_CLINT_msip        registered interrupt outputs
//
// Register map (offset from BASE_ADDR, low 3 offset bits ignored):
//   0x0000 msip (bit 0 only), 0x4000 mtimecmp, 0xBFF8 mtime
// ----------------------------------------------------------------------------
module ysyx_22040386_clint #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned MTIME_DIV = 1
) (
  input  logic        i_CLINT_clk,
  input  logic        i_CLINT_rst,
  input  logic        i_CLINT_req_valid,
  output logic        o_CLINT_req_ready,
  input  logic [63:0] i_CLINT_req_addr,
  input  logic        i_CLINT_req_wen,
  input  logic [63:0] i_CLINT_req_wdata,
  input  logic [7:0]  i_CLINT_req_wmask,
  output logic        o_CLINT_rsp_valid,
  input  logic        i_CLINT_rsp_ready,
  output logic [63:0] o_CLINT_rsp_rdata,
  output logic        o_CLINT_rsp_err,
  output logic        o_CLINT_mtip,
  output logic        o_CLINT_msip
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  // Word indices (offset >> 3) of the three mapped registers.
  localparam logic [12:0] WORD_MSIP     = 13'h0000;
  localparam logic [12:0] WORD_MTIMECMP = 13'h0800;
  localparam logic [12:0] WORD_MTIME    = 13'h17FF;

  localparam logic [15:0] PRESC_LAST = 16'(MTIME_DIV - 1);

  state_t      state_q, state_d;
  logic        msip_q, msip_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] mtime_q, mtime_d;
  logic [15:0] presc_q, presc_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mtip_q, mtip_d;

  // --------------------------------------------------------------------------
  // Address decode. The subtraction wraps for addresses below BASE_ADDR, so
  // those land far above 64 KiB and fall outside the window as well.
  // --------------------------------------------------------------------------
  logic [63:0] offset;
  logic        in_win;
  logic [12:0] word_idx;
  logic        sel_msip, sel_mtimecmp, sel_mtime, hit;
  logic        unused_offset_lsbs;

  assign offset       = i_CLINT_req_addr - BASE_ADDR;
  assign in_win       = (offset[63:16] == 48'd0);
  assign word_idx     = offset[15:3];
  assign sel_msip     = in_win && (word_idx == WORD_MSIP);
  assign sel_mtimecmp = in_win && (word_idx == WORD_MTIMECMP);
  assign sel_mtime    = in_win && (word_idx == WORD_MTIME);
  assign hit          = sel_msip | sel_mtimecmp | sel_mtime;
  assign unused_offset_lsbs = ^offset[2:0];

  // --------------------------------------------------------------------------
  // Byte-merged write values for the two 64-bit registers.
  // --------------------------------------------------------------------------
  logic [63:0] mtimecmp_wr, mtime_wr;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_merge
      assign mtimecmp_wr[gi*8 +: 8] = i_CLINT_req_wmask[gi] ? i_CLINT_req_wdata[gi*8 +: 8]
                                                            : mtimecmp_q[gi*8 +: 8];
      assign mtime_wr[gi*8 +: 8]    = i_CLINT_req_wmask[gi] ? i_CLINT_req_wdata[gi*8 +: 8]
                                                            : mtime_q[gi*8 +: 8];
    end
  endgenerate

  // Prescaler wrap marks an mtime tick edge.
  logic tick;
  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    state_d    = state_q;
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    presc_d    = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    // Compare on the values already in the registers, giving a one-cycle lag.
    mtip_d     = (mtime_q >= mtimecmp_q);

    case (state_q)
      ST_IDLE: begin
        if (i_CLINT_req_valid) begin
          state_d = ST_RESP;
          err_d   = ~hit;
          rdata_d = 64'd0;
          if (hit) begin
            if (i_CLINT_req_wen) begin
              if (sel_msip && i_CLINT_req_wmask[0]) msip_d = i_CLINT_req_wdata[0];
              if (sel_mtimecmp) mtimecmp_d = mtimecmp_wr;
              // A software write replaces the tick increment on the same edge.
              if (sel_mtime) mtime_d = mtime_wr;
            end else begin
              if (sel_msip)          rdata_d = {63'd0, msip_q};
              else if (sel_mtimecmp) rdata_d = mtimecmp_q;
              else                   rdata_d = mtime_q;
            end
          end
        end
      end
      ST_RESP: begin
        if (i_CLINT_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLINT_clk or posedge i_CLINT_rst) begin
    if (i_CLINT_rst) begin
      state_q    <= ST_IDLE;
      msip_q     <= 1'b0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtime_q    <= 64'd0;
      presc_q    <= 16'd0;
      rdata_q    <= 64'd0;
      err_q      <= 1'b0;
      mtip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
      presc_q    <= presc_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      mtip_q     <= mtip_d;
    end
  end

  assign o_CLINT_req_ready = (state_q == ST_IDLE);
  assign o_CLINT_rsp_valid = (state_q == ST_RESP);
  assign o_CLINT_rsp_rdata = rdata_q;
  assign o_CLINT_rsp_err   = err_q;
  assign o_CLINT_mtip      = mtip_q;
  assign o_CLINT_msip      = msip_q;

endmodule
